bitonic_sort_param: RTL and testbench

In-place bitonic sorter operating on an external simple dual-port RAM (one write port A, one registered read port B), with parameterised element count, key width and payload width. A runtime mode selects ascending or descending order. Sorting runs under a start/busy/done handshake. It is the parametrised successor of the fixed-size `bitonic_sort` and plugs into the same `ram_simple_dual` point RAM, which is sized `LOG2_N` address bits by `KEY_W+PAY_W` data bits.

---
 rtl/bitonic_sort_param_pkg.sv | 25 ++
 rtl/bitonic_cmp_swap.sv | 46 ++++
 rtl/bitonic_sort_param.sv | 141 ++++++++++++++
 tb/tb_bitonic_sort_param.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitonic_sort_param_pkg.sv
// Shared defaults, derived point-RAM geometry, FSM encoding and the pair
// address helper used by the parameterised bitonic sorter.
package bitonic_defines;

    localparam int DEF_LOG2_N        = 5;
    localparam int DEF_KEY_W         = 16;
    localparam int DEF_PAY_W         = 16;
    localparam int PT_RAM_ADDR_BITS  = DEF_LOG2_N;
    localparam int PT_RAM_DATA_WIDTH = DEF_KEY_W + DEF_PAY_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_NEXT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Lower address of pair p in pass j: p with a zero spliced in at bit j.
    function automatic int unsigned pair_lo(input int unsigned p, input int unsigned j);
        int unsigned low_mask;
        low_mask = (32'd1 << j) - 32'd1;
        return ((p >> j) << (j + 32'd1)) | (p & low_mask);
    endfunction

endpackage

// File: rtl/bitonic_cmp_swap.sv
// Compare-exchange of one word pair: the lo word leaves combinationally with the
// second read, the partner word is registered for the following write cycle.
module bitonic_cmp_swap #(
    parameter int KEY_W = 16,
    parameter int PAY_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_a,
    input  logic                   load_b,
    input  logic                   dir,
    input  logic [KEY_W+PAY_W-1:0] in_dat,
    output logic [KEY_W+PAY_W-1:0] lo_dat,
    output logic [KEY_W+PAY_W-1:0] hi_dat
);

    localparam int W = KEY_W + PAY_W;

    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     hi_q, hi_d;
    logic [KEY_W-1:0] key_a, key_b;
    logic             swap;

    always_comb begin
        key_a  = a_q[W-1:PAY_W];
        key_b  = in_dat[W-1:PAY_W];
        // Strict compare so equal keys keep their places.
        swap   = dir ? (key_b > key_a) : (key_a > key_b);
        lo_dat = swap ? in_dat : a_q;
        a_d    = load_a ? in_dat : a_q;
        hi_d   = load_b ? (swap ? a_q : in_dat) : hi_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            a_q  <= '0;
            hi_q <= '0;
        end else begin
            a_q  <= a_d;
            hi_q <= hi_d;
        end
    end

    assign hi_dat = hi_q;

endmodule

// File: rtl/bitonic_sort_param.sv
// In-place bitonic sort over a simple dual-port RAM; each pass streams N reads
// then N writes two cycles behind, N+2 cycles per pass, no backpressure.
module bitonic_sort_param
    import bitonic_defines::*;
#(
    parameter int LOG2_N = DEF_LOG2_N,
    parameter int KEY_W  = DEF_KEY_W,
    parameter int PAY_W  = DEF_PAY_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   descending,
    output logic                   busy,
    output logic                   done,
    output logic [LOG2_N-1:0]      ram_addra,
    output logic [KEY_W+PAY_W-1:0] ram_dia,
    output logic                   ram_we,
    output logic [LOG2_N-1:0]      ram_addrb,
    input  logic [KEY_W+PAY_W-1:0] ram_dob,
    output logic [3:0]             stage,
    output logic [3:0]             pass
);

    localparam int              CW     = LOG2_N + 2;
    localparam logic [CW-1:0]   N_C    = CW'(2 ** LOG2_N);
    localparam logic [3:0]      LAST_K = 4'(LOG2_N);

    state_t              state_q, state_d;
    logic [3:0]          stage_q, stage_d;
    logic [3:0]          pass_q, pass_d;
    logic [CW-1:0]       cyc_q, cyc_d;
    logic                desc_q, desc_d;

    logic [CW-1:0]       wr_cyc;
    logic [LOG2_N-1:0]   rd_pair, wr_pair;
    logic [LOG2_N-1:0]   rd_lo, rd_hi, wr_lo, wr_hi;
    logic                rd_en, wr_en, load_a, load_b, dir;
    logic [KEY_W+PAY_W-1:0] lo_dat, hi_dat;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            stage_q <= '0;
            pass_q  <= '0;
            cyc_q   <= '0;
            desc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            pass_q  <= pass_d;
            cyc_q   <= cyc_d;
            desc_q  <= desc_d;
        end
    end

    // NEXT carries the final hi write of a pass while the counters advance.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (cyc_q == N_C) state_d = ST_NEXT;
            ST_NEXT: state_d = (stage_q == LAST_K && pass_q == 4'd0) ? ST_DONE : ST_RUN;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        stage_d = stage_q;
        pass_d  = pass_q;
        cyc_d   = cyc_q;
        desc_d  = desc_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    stage_d = 4'd1;
                    pass_d  = 4'd0;
                    cyc_d   = '0;
                    desc_d  = descending;
                end
            end
            ST_RUN:  cyc_d = cyc_q + CW'(1);
            ST_NEXT: begin
                cyc_d = '0;
                if (pass_q != 4'd0) begin
                    pass_d = pass_q - 4'd1;
                end else if (stage_q != LAST_K) begin
                    stage_d = stage_q + 4'd1;
                    pass_d  = stage_q;
                end
            end
            default: begin
                stage_d = 4'd0;
                pass_d  = 4'd0;
            end
        endcase
    end

    always_comb begin
        wr_cyc  = cyc_q - CW'(2);
        rd_pair = LOG2_N'(cyc_q >> 1);
        wr_pair = LOG2_N'(wr_cyc >> 1);
        rd_lo   = LOG2_N'(pair_lo(32'(rd_pair), 32'(pass_q)));
        rd_hi   = rd_lo | LOG2_N'(32'd1 << pass_q);
        wr_lo   = LOG2_N'(pair_lo(32'(wr_pair), 32'(pass_q)));
        wr_hi   = wr_lo | LOG2_N'(32'd1 << pass_q);
        // Bit k of lo falls off the top in the last stage, giving one direction.
        dir     = (((32'(wr_lo) >> stage_q) & 32'd1) != 32'd0) ^ desc_q;
        rd_en   = (state_q == ST_RUN) && (cyc_q < N_C);
        wr_en   = (state_q == ST_RUN || state_q == ST_NEXT) && (cyc_q >= CW'(2));
        load_a  = rd_en && cyc_q[0];
        load_b  = wr_en && !cyc_q[0];
    end

    bitonic_cmp_swap #(
        .KEY_W (KEY_W),
        .PAY_W (PAY_W)
    ) u_cmp_swap (
        .clk    (clk),
        .rst    (rst),
        .load_a (load_a),
        .load_b (load_b),
        .dir    (dir),
        .in_dat (ram_dob),
        .lo_dat (lo_dat),
        .hi_dat (hi_dat)
    );

    always_comb begin
        busy      = (state_q == ST_RUN) || (state_q == ST_NEXT);
        done      = (state_q == ST_DONE);
        ram_we    = wr_en;
        ram_addrb = rd_en ? (cyc_q[0] ? rd_hi : rd_lo) : '0;
        ram_addra = wr_en ? (cyc_q[0] ? wr_hi : wr_lo) : '0;
        ram_dia   = wr_en ? (cyc_q[0] ? hi_dat : lo_dat) : '0;
        stage     = busy ? stage_q : 4'd0;
        pass      = busy ? pass_q : 4'd0;
    end

endmodule

// File: tb/tb_bitonic_sort_param.sv
// Bench for bitonic_sort_param: three sizes (N=32 with 8-bit keys, N=8, N=2),
// each on its own RAM model, checked against tables and a queue-sort reference.
module tb_bitonic_sort_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic [2:0]  start_v = '0, desc_v = '0;
    logic [2:0]  busy_v, done_v, we_v;
    logic [3:0]  stage_v [3];
    logic [3:0]  pass_v [3];
    logic [31:0] dia_v [3];
    logic [31:0] dob_v [3];
    logic [4:0]  addra_a, addrb_a;
    logic [2:0]  addra_b, addrb_b;
    logic [0:0]  addra_c, addrb_c;

    logic [31:0] mem_a [32];
    logic [31:0] mem_b [8];
    logic [31:0] mem_c [2];
    logic [2:0]  ld_v = '0;
    logic [4:0]  ld_addr = '0;
    logic [31:0] ld_dat = '0;
    logic [31:0] img [32];

    int cnt = 0;
    int nvec = 0;
    int nmis = 0;

    typedef struct {
        int   lat;
        int   nwr;
        int   last_wr;
        logic b1;
        logic bdone;
        logic dnext;
        logic [7:0] sp1;
        logic [7:0] sp2;
        logic [7:0] spa;
    } res_t;

    typedef struct packed {
        logic [7:0][15:0] key;
        logic             desc;
        logic [7:0][15:0] exp_key;
        logic [7:0][15:0] exp_pay;
    } vec_t;

    bitonic_sort_param #(.LOG2_N(5), .KEY_W(8), .PAY_W(24)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .descending(desc_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .ram_addra(addra_a), .ram_dia(dia_v[0]),
        .ram_we(we_v[0]), .ram_addrb(addrb_a), .ram_dob(dob_v[0]),
        .stage(stage_v[0]), .pass(pass_v[0]));

    bitonic_sort_param #(.LOG2_N(3), .KEY_W(16), .PAY_W(16)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .descending(desc_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .ram_addra(addra_b), .ram_dia(dia_v[1]),
        .ram_we(we_v[1]), .ram_addrb(addrb_b), .ram_dob(dob_v[1]),
        .stage(stage_v[1]), .pass(pass_v[1]));

    bitonic_sort_param #(.LOG2_N(1), .KEY_W(16), .PAY_W(16)) u_dut_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .descending(desc_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .ram_addra(addra_c), .ram_dia(dia_v[2]),
        .ram_we(we_v[2]), .ram_addrb(addrb_c), .ram_dob(dob_v[2]),
        .stage(stage_v[2]), .pass(pass_v[2]));

    always @(posedge clk) cnt <= cnt + 1;

    always @(posedge clk) begin
        if (we_v[0]) mem_a[addra_a] <= dia_v[0];
        else if (ld_v[0]) mem_a[ld_addr] <= ld_dat;
        if (we_v[1]) mem_b[addra_b] <= dia_v[1];
        else if (ld_v[1]) mem_b[ld_addr[2:0]] <= ld_dat;
        if (we_v[2]) mem_c[addra_c] <= dia_v[2];
        else if (ld_v[2]) mem_c[ld_addr[0]] <= ld_dat;
        dob_v[0] <= mem_a[addrb_a];
        dob_v[1] <= mem_b[addrb_b];
        dob_v[2] <= mem_c[addrb_c];
    end

    function automatic int l_of(input int which);
        return (which == 0) ? 5 : (which == 1) ? 3 : 1;
    endfunction

    function automatic logic [31:0] rd(input int which, input int i);
        case (which)
            0:       return mem_a[i];
            1:       return mem_b[i];
            default: return mem_c[i];
        endcase
    endfunction

    function automatic int key_of(input int which, input logic [31:0] w);
        return (which == 0) ? int'(w[31:24]) : int'(w[31:16]);
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic load(input int which);
        for (int i = 0; i < (1 << l_of(which)); i++) begin
            @(negedge clk);
            ld_v = '0;
            ld_v[which] = 1'b1;
            ld_addr = 5'(i);
            ld_dat = img[i];
        end
        @(negedge clk);
        ld_v = '0;
    endtask

    // One start pulse, then watch the sort cycle by cycle relative to the start sample.
    task automatic run(input int which, input logic desc, input int poke, output res_t r);
        int s;
        int rel;
        int n;
        n = 1 << l_of(which);
        r.lat = -1; r.nwr = 0; r.last_wr = -1;
        r.b1 = 1'b0; r.bdone = 1'b1; r.sp1 = '1; r.sp2 = '1;
        @(negedge clk);
        desc_v[which] = desc;
        start_v[which] = 1'b1;
        s = cnt;
        for (int k = 0; k < 2000 && r.lat < 0; k++) begin
            @(negedge clk);
            rel = cnt - s;
            start_v[which] = (rel == poke);
            desc_v[which] = ~desc;
            if (we_v[which]) begin
                r.nwr++;
                r.last_wr = rel;
            end
            if (rel == 1) begin
                r.b1 = busy_v[which];
                r.sp1 = {stage_v[which], pass_v[which]};
            end
            if (rel == n + 3) r.sp2 = {stage_v[which], pass_v[which]};
            if (done_v[which]) begin
                r.lat = rel;
                r.bdone = busy_v[which];
            end
        end
        start_v[which] = 1'b0;
        @(negedge clk);
        r.dnext = done_v[which];
        r.spa = {stage_v[which], pass_v[which]};
        desc_v[which] = 1'b0;
    endtask

    task automatic check_run(input int which, input res_t r, input string nm);
        int l, n, p;
        l = l_of(which);
        n = 1 << l;
        p = l * (l + 1) / 2;
        chk({nm, " done latency"}, r.lat, p * (n + 2) + 1);
        chk({nm, " last write"}, r.last_wr, p * (n + 2));
        chk({nm, " write count"}, r.nwr, p * n);
        chk({nm, " busy after start"}, r.b1, 1);
        chk({nm, " busy at done"}, r.bdone, 0);
        chk({nm, " done width"}, r.dnext, 0);
        chk({nm, " stage/pass first"}, r.sp1, 8'h10);
        chk({nm, " stage/pass second"}, r.sp2, (l >= 2) ? 8'h21 : 8'h00);
        chk({nm, " stage/pass idle"}, r.spa, 8'h00);
    endtask

    // Reference: keys in order via queue sort, and word multiset preserved.
    task automatic check_sorted(input int which, input logic desc, input string nm);
        int qk[$];
        logic [31:0] qi[$];
        logic [31:0] qo[$];
        logic [31:0] w;
        int n;
        n = 1 << l_of(which);
        for (int i = 0; i < n; i++) begin
            qk.push_back(key_of(which, img[i]));
            qi.push_back(img[i]);
            qo.push_back(rd(which, i));
        end
        if (desc) qk.rsort();
        else qk.sort();
        qi.sort();
        qo.sort();
        for (int i = 0; i < n; i++) begin
            w = rd(which, i);
            chk($sformatf("%s key@%0d", nm, i), key_of(which, w), qk[i]);
            chk($sformatf("%s multiset%0d", nm, i), qo[i], qi[i]);
        end
    endtask

    vec_t tbl [4];
    int   tk  [4][8] = '{'{7, 3, 6, 0, 5, 1, 4, 2}, '{7, 3, 6, 0, 5, 1, 4, 2},
                         '{170, 170, 170, 170, 170, 170, 170, 170}, '{10, 11, 12, 13, 14, 15, 16, 17}};
    int   td  [4]    = '{0, 1, 0, 0};
    int   tek [4][8] = '{'{0, 1, 2, 3, 4, 5, 6, 7}, '{7, 6, 5, 4, 3, 2, 1, 0},
                         '{170, 170, 170, 170, 170, 170, 170, 170}, '{10, 11, 12, 13, 14, 15, 16, 17}};
    int   tep [4][8] = '{'{3, 5, 7, 1, 6, 4, 2, 0}, '{0, 2, 4, 6, 1, 7, 5, 3},
                         '{0, 1, 2, 3, 4, 5, 6, 7}, '{0, 1, 2, 3, 4, 5, 6, 7}};

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res_t        r;
        logic [31:0] w;
        logic        d;
        int          s;

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 8; i++) begin
                tbl[t].key[i]     = 16'(tk[t][i]);
                tbl[t].exp_key[i] = 16'(tek[t][i]);
                tbl[t].exp_pay[i] = 16'(tep[t][i]);
            end
            tbl[t].desc = (td[t] != 0);
        end

        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset busy", busy_v, 3'b000);
        chk("reset done", done_v, 3'b000);
        chk("reset we", we_v, 3'b000);
        chk("reset stage/pass", {stage_v[0], pass_v[0]}, 8'h00);
        chk("reset addresses", {addra_a, addrb_a}, 10'd0);
        chk("reset dia", dia_v[0], 32'd0);
        rst = 1'b1;

        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 8; i++) img[i] = {tbl[t].key[i], 16'(i)};
            load(1);
            run(1, tbl[t].desc, -1, r);
            check_run(1, r, $sformatf("tbl%0d", t));
            for (int i = 0; i < 8; i++) begin
                w = rd(1, i);
                chk($sformatf("tbl%0d key@%0d", t, i), w[31:16], tbl[t].exp_key[i]);
                chk($sformatf("tbl%0d pay@%0d", t, i), w[15:0], tbl[t].exp_pay[i]);
            end
        end

        img[0] = {16'd9, 16'd0};
        img[1] = {16'd4, 16'd1};
        load(2);
        run(2, 1'b0, -1, r);
        check_run(2, r, "n2");
        chk("n2 word0", rd(2, 0), {16'd4, 16'd1});
        chk("n2 word1", rd(2, 1), {16'd9, 16'd0});

        for (int i = 0; i < 32; i++) img[i] = {8'(31 - i), 24'(i)};
        load(0);
        run(0, 1'b1, 40, r);
        check_run(0, r, "presorted");
        for (int i = 0; i < 32; i++) chk($sformatf("presorted word%0d", i), rd(0, i), img[i]);

        for (int run_i = 0; run_i < 100; run_i++) begin
            d = 1'($urandom_range(0, 1));
            for (int i = 0; i < 32; i++) img[i] = {8'($urandom_range(0, 255)), 24'($urandom)};
            load(0);
            run(0, d, -1, r);
            check_run(0, r, $sformatf("rand%0d", run_i));
            check_sorted(0, d, $sformatf("rand%0d", run_i));
        end

        for (int i = 0; i < 32; i++) img[i] = {8'($urandom_range(0, 255)), 24'(i)};
        load(0);
        @(negedge clk);
        start_v[0] = 1'b1;
        s = cnt;
        @(negedge clk);
        start_v[0] = 1'b0;
        for (int k = 0; k < 300 && cnt < s + 200; k++) @(negedge clk);
        chk("busy before reset", busy_v[0], 1'b1);
        rst = 1'b0;
        @(negedge clk);
        chk("midreset we", we_v[0], 1'b0);
        chk("midreset busy", busy_v[0], 1'b0);
        chk("midreset done", done_v[0], 1'b0);
        chk("midreset stage/pass", {stage_v[0], pass_v[0]}, 8'h00);
        chk("midreset addresses", {addra_a, addrb_a}, 10'd0);
        chk("midreset dia", dia_v[0], 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 32; i++) img[i] = {8'($urandom_range(0, 255)), 24'($urandom)};
        load(0);
        run(0, 1'b1, -1, r);
        check_run(0, r, "after reset");
        check_sorted(0, 1'b1, "after reset");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
